// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake, operands and registered result.
// The ovf line exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf;
    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell plus borrow flop.
// Defining SERIAL_SUB_OVERFLOW_EN adds a registered signed-overflow flag (ovf).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_subtractor_if.slave s
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] x_sr, y_sr, r_sr, diff_q;
    logic [CW-1:0]    cnt;
    logic             br, bout_q;
    logic             d, br_nxt, accept, last;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb, b_msb, ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        d         = x_sr[0] ^ y_sr[0] ^ br;
        br_nxt    = (~x_sr[0] & y_sr[0]) | (~(x_sr[0] ^ y_sr[0]) & br);
        accept    = (state != SHIFT) && s.start;
        last      = cnt == CW'(WIDTH - 1);
        state_nxt = accept ? SHIFT : (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

    // Operands capture on accept; outputs only move on the final shift so they stay stable during SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sr   <= '0;
            y_sr   <= '0;
            r_sr   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            x_sr   <= s.a;
            y_sr   <= s.b;
            br     <= s.bin;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= s.a[WIDTH-1];
            b_msb  <= s.b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            x_sr <= x_sr >> 1;
            y_sr <= y_sr >> 1;
            r_sr <= {d, r_sr[WIDTH-1:1]};
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff_q <= {d, r_sr[WIDTH-1:1]};
                bout_q <= br_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
                ovf_q  <= (a_msb != b_msb) && (d != a_msb);
`endif
            end
        end
    end

    assign s.busy = state == SHIFT;
    assign s.done = state == DONE;
    assign s.diff = diff_q;
    assign s.bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign s.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model.
// Builds with or without SERIAL_SUB_OVERFLOW_EN; ovf is checked only when it exists.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic void ref_sub(input logic [W-1:0] a, b, input logic bi,
                                    output logic [W-1:0] d, output logic bo, ov);
        logic [W:0] t;
        longint sa, sb, sr;
        t  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        d  = t[W-1:0];
        bo = t[W];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = sa - sb - longint'(bi);
        ov = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
    endfunction

    // Issues one op; optionally pulses a conflicting start at sample 'poke' while the op is in SHIFT.
    task automatic do_op(input logic now, input int poke, input logic [W-1:0] a, b, input logic bi,
                         output logic [W-1:0] d, output logic bo, ov, output int lat, bc);
        if (!now) @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bi;
        lat = 0;
        bc = 0;
        @(negedge clk);
        lat = 1;
        while (!bus.done && lat < 4 * W) begin
            if (bus.busy) bc++;
            if (lat == poke) begin
                bus.start = 1'b1;
                bus.a = ~a;
                bus.b = a;
                bus.bin = ~bi;
            end else bus.start = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        d = bus.diff;
        bo = bus.bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ov = bus.ovf;
`else
        ov = 1'b0;
`endif
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.diff !== '0) begin failures++; $display("FAIL reset_diff got=%h exp=0", bus.diff); end
        checks++; if (bus.bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bus.bout); end
`ifdef SERIAL_SUB_OVERFLOW_EN
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat, bc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = W'(8'h55);
        bus.b = W'(8'h11);
        bus.bin = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
        checks++; if (bus.diff !== '0) begin failures++; $display("FAIL midrst_diff got=%h exp=0", bus.diff); end
        checks++; if (bus.bout !== 1'b0) begin failures++; $display("FAIL midrst_bout got=%b exp=0", bus.bout); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 0, W'(8'h0A), W'(8'h03), 1'b0, d, bo, ov, lat, bc);
        ref_sub(W'(8'h0A), W'(8'h03), 1'b0, ed, ebo, eov);
        checks++; if (d !== ed) begin failures++; $display("FAIL postrst_diff got=%h exp=%h", d, ed); end
        checks++; if (bo !== ebo) begin failures++; $display("FAIL postrst_bout got=%b exp=%b", bo, ebo); end
    endtask

    task automatic test_basic();
        logic [W-1:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat, bc;
        do_op(1'b0, 0, W'(8'h3C), W'(8'h15), 1'b0, d, bo, ov, lat, bc);
        ref_sub(W'(8'h3C), W'(8'h15), 1'b0, ed, ebo, eov);
        checks++; if (d !== ed) begin failures++; $display("FAIL basic_diff got=%h exp=%h", d, ed); end
        checks++; if (bo !== ebo) begin failures++; $display("FAIL basic_bout got=%b exp=%b", bo, ebo); end
        checks++; if (lat !== W + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
        checks++; if (bc !== W) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, W); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
        checks++; if (bus.diff !== ed) begin failures++; $display("FAIL basic_diff_hold got=%h exp=%h", bus.diff, ed); end
    endtask

    task automatic test_borrow();
        logic [W-1:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat, bc;
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic tbi [2];
        ta[0] = W'(8'h00); tb[0] = W'(8'h01); tbi[0] = 1'b0;
        ta[1] = W'(8'h05); tb[1] = W'(8'h05); tbi[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_op(1'b0, 0, ta[i], tb[i], tbi[i], d, bo, ov, lat, bc);
            ref_sub(ta[i], tb[i], tbi[i], ed, ebo, eov);
            checks++; if (d !== ed) begin failures++; $display("FAIL borrow%0d_diff got=%h exp=%h", i, d, ed); end
            checks++; if (bo !== ebo) begin failures++; $display("FAIL borrow%0d_bout got=%b exp=%b", i, bo, ebo); end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat, bc;
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        ta[0] = W'(8'h80); tb[0] = W'(8'h01);
        ta[1] = W'(8'h10); tb[1] = W'(8'h20);
        for (int i = 0; i < 2; i++) begin
            do_op(1'b0, 0, ta[i], tb[i], 1'b0, d, bo, ov, lat, bc);
            ref_sub(ta[i], tb[i], 1'b0, ed, ebo, eov);
            checks++; if (d !== ed) begin failures++; $display("FAIL ovf%0d_diff got=%h exp=%h", i, d, ed); end
            checks++; if (bo !== ebo) begin failures++; $display("FAIL ovf%0d_bout got=%b exp=%b", i, bo, ebo); end
`ifdef SERIAL_SUB_OVERFLOW_EN
            checks++; if (ov !== eov) begin failures++; $display("FAIL ovf%0d_ovf got=%b exp=%b", i, ov, eov); end
`endif
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat, bc;
        do_op(1'b0, 2, W'(8'h9A), W'(8'h4E), 1'b1, d, bo, ov, lat, bc);
        ref_sub(W'(8'h9A), W'(8'h4E), 1'b1, ed, ebo, eov);
        checks++; if (d !== ed) begin failures++; $display("FAIL ignore_diff got=%h exp=%h", d, ed); end
        checks++; if (bo !== ebo) begin failures++; $display("FAIL ignore_bout got=%b exp=%b", bo, ebo); end
        checks++; if (lat !== W + 1) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W + 1); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat, bc;
        do_op(1'b0, 0, W'(8'hC3), W'(8'h5A), 1'b0, d, bo, ov, lat, bc);
        ref_sub(W'(8'hC3), W'(8'h5A), 1'b0, ed, ebo, eov);
        checks++; if (d !== ed) begin failures++; $display("FAIL b2b_first_diff got=%h exp=%h", d, ed); end
        do_op(1'b1, 0, W'(8'h21), W'(8'h7F), 1'b1, d, bo, ov, lat, bc);
        ref_sub(W'(8'h21), W'(8'h7F), 1'b1, ed, ebo, eov);
        checks++; if (lat !== W + 1) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", lat, W + 1); end
        checks++; if (d !== ed) begin failures++; $display("FAIL b2b_second_diff got=%h exp=%h", d, ed); end
        checks++; if (bo !== ebo) begin failures++; $display("FAIL b2b_second_bout got=%b exp=%b", bo, ebo); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, d, ed;
        logic bi, bo, ov, ebo, eov;
        int lat, bc;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            bi = 1'($urandom_range(0, 1));
            do_op(1'b0, 0, a, b, bi, d, bo, ov, lat, bc);
            ref_sub(a, b, bi, ed, ebo, eov);
            checks++;
            if (d !== ed || bo !== ebo || lat !== W + 1) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h bin=%b got diff=%h bout=%b lat=%0d exp diff=%h bout=%b lat=%0d",
                         i, a, b, bi, d, bo, lat, ed, ebo, W + 1);
            end
`ifdef SERIAL_SUB_OVERFLOW_EN
            checks++; if (ov !== eov) begin failures++; $display("FAIL rand%0d_ovf got=%b exp=%b", i, ov, eov); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_borrow();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b - bin` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the ripple full-adder datapath, for area-constrained arithmetic paths where WIDTH+1 cycles of latency is acceptable. A start/busy/done handshake lets a controller issue operations back to back.

## Interface
- `WIDTH`, default 8, operand and result width in bits (≥ 2).

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request a new operation; sampled only when `busy` = 0.
- `a` input WIDTH: minuend; captured on the accepted `start` edge.
- `b` input WIDTH: subtrahend; captured on the accepted `start` edge.
- `bin` input 1: borrow-in; captured on the accepted `start` edge.
- `busy` output 1: high while bits are being processed.
- `done` output 1: single-cycle pulse; `diff`/`bout` valid.
- `diff` output WIDTH: registered difference, held until the next completion.
- `bout` output 1: registered borrow-out; 1 means `a < b + bin` unsigned.
- `ovf` output 1: signed overflow. Present only with `SERIAL_SUB_OVERFLOW_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1:
  - Load `a` and `b` into internal shift registers.
  - Load the borrow register with `bin`.
  - Clear the bit counter.
  - Go to SHIFT.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- SHIFT, each cycle, using the operand LSBs `x`, `y` and borrow `br`:
  - Difference bit `d` = x ^ y ^ br.
  - Next borrow = (~x & y) | (~(x ^ y) & br).
  - Both operand registers shift right by 1.
  - `d` is inserted at the MSB of the internal result register, which also shifts right.
  - The counter increments.
- SHIFT with counter = WIDTH-1:
  - Copy the final result into `diff`.
  - Copy the final borrow into `bout`.
  - Go to DONE.
- `start` is ignored while in SHIFT; no queuing.
- Arithmetic is modulo 2^WIDTH. `bout` is the unsigned borrow out of the MSB.
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0. Internal registers and the counter are also 0.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs at reset values. No partial result is presented.

## Timing
- Edge E0 samples `start`=1 with `busy`=0.
- `busy`=1 from after E0 until after E(WIDTH).
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- After E(WIDTH):
  - State is DONE.
  - `done`=1 and `busy`=0.
  - `diff`, `bout` (and `ovf`) are updated in the same cycle.
- `done` drops after E(WIDTH+1).
- Latency is WIDTH+1 edges from start to the `done` sample.
- Back-to-back: `start` held in the DONE cycle is accepted. `busy` rises the next cycle, giving a throughput of one result per WIDTH+1 cycles.
- Outputs do not change during SHIFT. `diff`/`bout` keep the previous result until the next DONE.

## Configuration
- Macro: `SERIAL_SUB_OVERFLOW_EN`.
- Defined:
  - Port `ovf` exists.
  - Registered alongside `diff`: `ovf` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
  - Two's-complement semantics.
- Undefined: port `ovf` and its logic are absent. All other behaviour is identical.

## Test plan
- Reset mid-op, WIDTH=8:
  - Start with a=0x55, b=0x11, then drop `rst_n` at E3 → all outputs 0 at once, state IDLE.
  - Next start with a=0x0A, b=0x03, bin=0 → `diff`=0x07, `bout`=0.
- Basic, WIDTH=8: a=0x3C, b=0x15, bin=0 → after 9 edges, `done` pulses one cycle with `diff`=0x27, `bout`=0. `busy` is high for exactly 8 cycles.
- Borrow out: a=0x00, b=0x01, bin=0 → `diff`=0xFF, `bout`=1. Also a=0x05, b=0x05, bin=1 → `diff`=0xFF, `bout`=1.
- Overflow (macro defined): a=0x80, b=0x01 → `diff`=0x7F, `ovf`=1. Then a=0x10, b=0x20 → `diff`=0xF0, `ovf`=0, `bout`=1.
- Handshake:
  - Pulse `start` during SHIFT with different operands → ignored, original result returned.
  - Hold `start` in the DONE cycle → second op accepted, second `done` exactly 9 cycles after the first.
- Random: 1000 random a, b, bin, compared against a reference model. Cover both macro settings and WIDTH=2 and WIDTH=16.
